// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator.
// Holds the standard 640x480@60 geometry, the derived totals and sync
// window positions, the packed rgb_t colour type and the colour-bar table
// used by the optional test pattern.
package vga_pkg;

    localparam int STD_H_VISIBLE = 640;
    localparam int STD_H_FRONT   = 16;
    localparam int STD_H_SYNC    = 96;
    localparam int STD_H_BACK    = 48;
    localparam int STD_V_VISIBLE = 480;
    localparam int STD_V_FRONT   = 10;
    localparam int STD_V_SYNC    = 2;
    localparam int STD_V_BACK    = 33;

    localparam int H_TOTAL      = STD_H_VISIBLE + STD_H_FRONT + STD_H_SYNC + STD_H_BACK;
    localparam int V_TOTAL      = STD_V_VISIBLE + STD_V_FRONT + STD_V_SYNC + STD_V_BACK;
    localparam int H_SYNC_START = STD_H_VISIBLE + STD_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + STD_H_SYNC;
    localparam int V_SYNC_START = STD_V_VISIBLE + STD_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + STD_V_SYNC;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    // Bar 0 is the leftmost eighth of the visible line.
    function automatic rgb_t bar_color(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle between the timing generator, the colour datapath and the DAC.
//   dato        colour word returned by the colour datapath
//   pixelX/Y    current pixel counters
//   pix_en      pixel-tick strobe
//   frame_start strobe on wrap to (0,0)
//   vga_clk, hsync, vsync, blank_n, sync_n, r/g/b   DAC side
// master: the timing generator. slave: the colour datapath / DAC side.
interface vga_timing_gen_if;
    logic [31:0] dato;
    logic [9:0]  pixelX;
    logic [9:0]  pixelY;
    logic        pix_en;
    logic        frame_start;
    logic        vga_clk;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        sync_n;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;

    modport master (
        input  dato,
        output pixelX, pixelY, pix_en, frame_start,
        output vga_clk, hsync, vsync, blank_n, sync_n, r, g, b
    );

    modport slave (
        output dato,
        input  pixelX, pixelY, pix_en, frame_start,
        input  vga_clk, hsync, vsync, blank_n, sync_n, r, g, b
    );
endinterface

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align sync/visibility with the
// colour returned by the datapath.
//   clk, rst  clock, synchronous active-high reset (all stages -> RESET_VAL)
//   en        advance one stage
//   d / q     input word / word shifted in DEPTH enables ago
// DEPTH=0 is a pure wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctl;
            assign unused_ctl = clk ^ rst ^ en;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator (640x480@60 by default).
// Produces pixel counters for the colour datapath, takes back its colour
// word PIX_LAT pixel ticks later and drives sync/blank/RGB to the DAC with
// sync delayed to line up with colour: pixel (x,y) reaches r/g/b
// PIX_LAT+1 ticks after pixelX/Y=(x,y).
//   clk, rst   system clock, synchronous active-high reset
//   test_mode  (only with VGA_TEST_PATTERN_EN) colour bars instead of dato
//   vif        vga_timing_gen_if.master: dato in; counters, strobes, DAC out
// Build option VGA_TEST_PATTERN_EN adds the test_mode colour-bar pattern.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = STD_H_VISIBLE,
    parameter int H_FRONT   = STD_H_FRONT,
    parameter int H_SYNC    = STD_H_SYNC,
    parameter int H_BACK    = STD_H_BACK,
    parameter int V_VISIBLE = STD_V_VISIBLE,
    parameter int V_FRONT   = STD_V_FRONT,
    parameter int V_SYNC    = STD_V_SYNC,
    parameter int V_BACK    = STD_V_BACK,
    parameter int CLK_DIV   = 2,
    parameter int PIX_LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    vga_timing_gen_if.master vif
);

    localparam int H_TOT    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DIV_W    = $clog2(CLK_DIV);

    logic [DIV_W-1:0] div, div_nxt;
    logic [9:0]       h, v;
    logic             pix_en, h_wrap, v_wrap;
    logic             vga_clk_q;

    assign pix_en  = (div == DIV_W'(CLK_DIV - 1));
    assign div_nxt = pix_en ? '0 : div + 1'b1;
    assign h_wrap  = (h == 10'(H_TOT - 1));
    assign v_wrap  = (v == 10'(V_TOT - 1));

    // vga_clk is computed from the next divider value so that, once
    // registered, it reflects the divider phase of the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            h         <= '0;
            v         <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            div       <= div_nxt;
            vga_clk_q <= (div_nxt >= DIV_W'(CLK_DIV / 2));
            if (pix_en) begin
                h <= h_wrap ? '0 : h + 10'd1;
                if (h_wrap) v <= v_wrap ? '0 : v + 10'd1;
            end
        end
    end

    logic hs_raw, vs_raw, vis_raw;
    assign hs_raw  = !((h >= 10'(HS_START)) && (h < 10'(HS_END)));
    assign vs_raw  = !((v >= 10'(VS_START)) && (v < 10'(VS_END)));
    assign vis_raw = (h < 10'(H_VISIBLE)) && (v < 10'(V_VISIBLE));

`ifdef VGA_TEST_PATTERN_EN
    localparam int             DL_W   = 6;
    localparam logic [DL_W-1:0] DL_RST = 6'b110_000;
`else
    localparam int             DL_W   = 3;
    localparam logic [DL_W-1:0] DL_RST = 3'b110;
`endif

    logic [DL_W-1:0] dl_in, dl_out;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index travels with sync so the pattern stays aligned like dato.
    logic [2:0] bar_raw;
    assign bar_raw = 3'(h / 10'(H_VISIBLE / 8));
    assign dl_in   = {hs_raw, vs_raw, vis_raw, bar_raw};
`else
    assign dl_in   = {hs_raw, vs_raw, vis_raw};
`endif

    vga_delay_line #(
        .WIDTH     (DL_W),
        .DEPTH     (PIX_LAT),
        .RESET_VAL (DL_RST)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (dl_in),
        .q   (dl_out)
    );

    logic hs_d, vs_d, vis_d;
    assign {hs_d, vs_d, vis_d} = dl_out[DL_W-1 -: 3];

    rgb_t pix_rgb, rgb_q;
`ifdef VGA_TEST_PATTERN_EN
    assign pix_rgb = test_mode ? bar_color(dl_out[2:0]) : rgb_t'(vif.dato[23:0]);
`else
    assign pix_rgb = rgb_t'(vif.dato[23:0]);
`endif

    logic hsync_q, vsync_q, blank_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            blank_q <= 1'b0;
            rgb_q   <= '0;
        end else if (pix_en) begin
            hsync_q <= hs_d;
            vsync_q <= vs_d;
            blank_q <= vis_d;
            rgb_q   <= vis_d ? pix_rgb : '0;
        end
    end

    logic [7:0] unused_dato_msb;
    assign unused_dato_msb = vif.dato[31:24];

    assign vif.pixelX      = h;
    assign vif.pixelY      = v;
    assign vif.pix_en      = pix_en;
    assign vif.frame_start = pix_en & h_wrap & v_wrap;
    assign vif.vga_clk     = vga_clk_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.blank_n     = blank_q;
    assign vif.sync_n      = 1'b0;
    assign vif.r           = rgb_q.r;
    assign vif.g           = rgb_q.g;
    assign vif.b           = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800-pixel lines with a short 12-line frame
// so whole frames fit in a short run. Outputs are predicted from the clock
// count since reset using plain position arithmetic.
module tb_vga_timing_gen;

    localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VV = 6, VF = 2, VSW = 2, VB = 2;
    localparam int CD = 2, L = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if vif();
`ifdef VGA_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(CD), .PIX_LAT(L)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode (test_mode),
`endif
        .vif (vif)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int px(int m); return m % HT; endfunction
    function automatic int py(int m); return (m / HT) % VT; endfunction
    function automatic bit vis(int m); return px(m) < HV && py(m) < VV; endfunction
    function automatic bit hsl(int m); return px(m) >= HV + HF && px(m) < HV + HF + HSW; endfunction
    function automatic bit vsl(int m); return py(m) >= VV + VF && py(m) < VV + VF + VSW; endfunction
    function automatic logic [23:0] enc(int x, int y, logic [7:0] b);
        logic [9:0] xv;
        logic [5:0] yv;
        xv = 10'(x);
        yv = 6'(y);
        return {xv[7:0], yv, xv[9:8], b};
    endfunction

    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Clocks since the last reset edge; everything else follows from this.
    int c = 0;
    always @(posedge clk) c <= rst ? 0 : c + 1;

    logic [7:0] bring [16];

    // Colour datapath echo: during tick k return the colour for the
    // coordinates shown L ticks earlier (random blue/top byte).
    initial begin
        forever begin
            int k, src;
            logic [7:0] bv;
            @(negedge clk);
            k = c / CD;
            src = k - L;
            if (src >= 0 && vis(src)) begin
                bv = 8'($urandom);
                bring[k % 16] = bv;
                vif.dato = {8'($urandom), enc(px(src), py(src), bv)};
            end else begin
                vif.dato = 32'h0056B000;
            end
        end
    end

    bit chk_en = 0, stats_en = 0;
    int first_hs = -1, last_hs = -1, first_vs = -1, last_vs = -1;
    int first_fs = -1, last_fs = -1, fs_cnt = 0, ymax = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    always @(negedge clk) begin
        int n, d, s;
        logic tm;
        logic [23:0] rgb_e;
        if (chk_en) begin
            n = c / CD;
            d = c % CD;
            s = n - 1 - L;
            tm = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            tm = test_mode;
`endif
            rgb_e = 24'h0;
            if (s >= 0 && vis(s)) rgb_e = tm ? bars[px(s) / 80] : enc(px(s), py(s), bring[(n - 1) % 16]);
            chk("pixelX", 32'(vif.pixelX), px(n));
            chk("pixelY", 32'(vif.pixelY), py(n));
            chk("pix_en", 32'(vif.pix_en), 32'(d == CD - 1));
            chk("vga_clk", 32'(vif.vga_clk), 32'(d >= CD / 2));
            chk("frame_start", 32'(vif.frame_start), 32'(d == CD - 1 && px(n) == HT - 1 && py(n) == VT - 1));
            chk("hsync", 32'(vif.hsync), 32'(s < 0 || !hsl(s)));
            chk("vsync", 32'(vif.vsync), 32'(s < 0 || !vsl(s)));
            chk("blank_n", 32'(vif.blank_n), 32'(s >= 0 && vis(s)));
            chk("sync_n", 32'(vif.sync_n), 32'd0);
            chk("rgb", 32'({vif.r, vif.g, vif.b}), 32'(rgb_e));

            if (stats_en && d == 0 && c > 0) begin
                if (prev_hs && !vif.hsync) begin
                    if (first_hs < 0) first_hs = n; else chk("hs_period", n - last_hs, HT);
                    last_hs = n;
                end
                if (!prev_hs && vif.hsync && last_hs >= 0) chk("hs_width", n - last_hs, HSW);
                prev_hs = vif.hsync;
                if (prev_vs && !vif.vsync) begin
                    if (first_vs < 0) first_vs = n; else chk("vs_period", n - last_vs, HT * VT);
                    last_vs = n;
                end
                if (!prev_vs && vif.vsync && last_vs >= 0) chk("vs_width", n - last_vs, VSW * HT);
                prev_vs = vif.vsync;
                if (int'(vif.pixelY) > ymax) ymax = int'(vif.pixelY);
            end
            if (stats_en && vif.frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = n; else chk("fs_spacing", n - last_fs, HT * VT);
                last_fs = n;
            end
        end
    end

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (c != target * CD && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (c != target * CD) chk("wait_timeout", 32'(c), 32'(target * CD));
    endtask

    initial begin
        int found, lowcnt;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_hsync", 32'(vif.hsync), 1);
        chk("rst_vsync", 32'(vif.vsync), 1);
        chk("rst_blank", 32'(vif.blank_n), 0);
        chk("rst_rgb", 32'({vif.r, vif.g, vif.b}), 0);
        chk("rst_pixelX", 32'(vif.pixelX), 0);
        chk("rst_pixelY", 32'(vif.pixelY), 0);

        // Two free-running frames with sync/frame statistics.
        rst = 1'b0;
        stats_en = 1;
        repeat (2 * HT * VT * CD + 4) @(negedge clk);
        stats_en = 0;
        chk("hs_first_fall", first_hs, 659);
        chk("vs_first_fall", first_vs, 6403);
        chk("fs_first", first_fs, 9599);
        chk("fs_count", fs_cnt, 2);
        chk("pixelY_max", ymax, 11);

        // Reset in the middle of a visible line.
        found = 0;
        for (int i = 0; i < 2 * HT * VT * CD && found == 0; i++) begin
            @(negedge clk);
            if (vif.pixelX == 10'd300 && vif.pixelY == 10'd3) found = 1;
        end
        chk("find_300_3", found, 1);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_hsync", 32'(vif.hsync), 1);
            chk("midrst_vsync", 32'(vif.vsync), 1);
            chk("midrst_pixelX", 32'(vif.pixelX), 0);
        end
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            @(negedge clk);
            if (vif.pix_en) found = 1;
        end
        chk("post_rst_pix_en", found, 1);
        @(negedge clk);
        chk("post_rst_pixelX", 32'(vif.pixelX), 1);
        chk("post_rst_pixelY", 32'(vif.pixelY), 0);
        lowcnt = 0;
        for (int i = 0; i < 4000 && c < CD * 660; i++) begin
            @(negedge clk);
            if (c / CD < 659 && (!vif.hsync || !vif.vsync)) lowcnt++;
        end
        chk("no_early_sync", lowcnt, 0);
        chk("hsync_natural", 32'(vif.hsync), 0);
        chk("vsync_natural", 32'(vif.vsync), 1);

`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_n(3);   chk("bar_x0", 32'({vif.r, vif.g, vif.b}), 32'h00FFFFFF);
        wait_n(82);  chk("bar_x79", 32'({vif.r, vif.g, vif.b}), 32'h00FFFFFF);
        wait_n(83);  chk("bar_x80", 32'({vif.r, vif.g, vif.b}), 32'h00FFFF00);
        wait_n(563); chk("bar_x560", 32'({vif.r, vif.g, vif.b}), 32'h0);
        chk("bar_x560_blank", 32'(vif.blank_n), 1);
        wait_n(642); chk("bar_x639", 32'({vif.r, vif.g, vif.b}), 32'h0);
        wait_n(643); chk("bar_x640_blank", 32'(vif.blank_n), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
